// File: rtl/div_sequencer.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU with its own IDLE/ITER/FIX/DONE sequencer.
// Optional DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_flush,
    output logic        o_div_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_q;
    logic [32:0] r_divisor;
    logic        r_qsign;
    logic        r_rsign;
    logic        r_signed;
    logic        r_dbz;

    logic        w_accept;
    logic        w_zero;
    logic        w_early;
    logic [32:0] w_abs_a;
    logic [32:0] w_abs_b;
    logic [33:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    // 33-bit magnitude so that -2^31 stays representable
    function automatic logic [32:0] f_abs33(input logic [31:0] v, input logic sgn);
        logic signed [32:0] s;
        s = $signed({sgn & v[31], v});
        return (s < 0) ? $unsigned(-s) : $unsigned(s);
    endfunction

    function automatic logic [31:0] f_neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    assign w_abs_a  = f_abs33(i_dividend, i_signed);
    assign w_abs_b  = f_abs33(i_divisor, i_signed);
    assign w_zero   = (i_divisor == 32'd0);
    assign w_accept = (r_state == S_IDLE) & i_start & ~i_flush;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = ~w_zero & (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // one restoring step: shift {rem, q} left and trial-subtract the divisor
    assign w_shift = {r_rem, r_q[31]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = w_shift[32:0] - r_divisor;

    always_comb begin
        w_next     = r_state;
        o_div_busy = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_div_busy = i_start & ~i_flush;
                if (w_accept)
                    w_next = (w_zero | w_early) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                o_div_busy = ~i_flush;
                if (i_flush)
                    w_next = S_IDLE;
                else if (r_cnt == 6'd31)
                    w_next = S_FIX;
            end
            S_FIX: begin
                o_div_busy = ~i_flush;
                w_next     = i_flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                o_done = ~i_flush;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= 6'd0;
            else if (r_state == S_ITER)
                r_cnt <= r_cnt + 6'd1;
        end
    end

    // operand and iteration datapath; control alone decides when it matters
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_divisor <= w_abs_b;
            r_qsign   <= i_dividend[31] ^ i_divisor[31];
            r_rsign   <= i_dividend[31];
            r_signed  <= i_signed;
            r_dbz     <= w_zero;
            if (w_zero) begin
                r_q   <= 32'hFFFF_FFFF;
                r_rem <= {1'b0, i_dividend};
            end else if (w_early) begin
                r_q   <= 32'd0;
                r_rem <= w_abs_a;
            end else begin
                {r_rem, r_q} <= {32'd0, w_abs_a};
            end
        end else if (r_state == S_ITER) begin
            r_rem <= w_ge ? w_diff : w_shift[32:0];
            r_q   <= {r_q[30:0], w_ge};
        end
    end

    // sign correction and result capture; divide-by-zero results pass through raw
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_quotient    <= 32'd0;
            o_remainder   <= 32'd0;
            o_div_by_zero <= 1'b0;
        end else if ((r_state == S_FIX) && !i_flush) begin
            o_quotient    <= r_dbz ? r_q : f_neg32(r_q, r_signed & r_qsign);
            o_remainder   <= r_dbz ? r_rem[31:0] : f_neg32(r_rem[31:0], r_signed & r_rsign);
            o_div_by_zero <= r_dbz;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected results, latency and busy/done checks.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_flush;
    logic        o_div_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_by_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic [31:0] lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] last_q   = 32'd0;
    logic [31:0] last_r   = 32'd0;
    logic [31:0] last_dbz = 32'd0;

    div_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_signed     (i_signed),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .i_flush      (i_flush),
        .o_div_busy   (o_div_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, qq, rr, ma, mb;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dbz = 1'b1;
            e.lat = 32'd2;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'(a);
            sb = sgn ? longint'($signed(b)) : longint'(b);
            qq = sa / sb;
            rr = sa % sb;
            e.q = qq[31:0];
            e.r = rr[31:0];
            e.dbz = 1'b0;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            e.lat = 32'd34;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) e.lat = 32'd2;
`else
            if (ma < mb) e.lat = 32'd34;
`endif
        end
        return e;
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns just after the edge leaving DONE.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   cyc;
        int   busy_err;
        sb_q.push_back(model(sgn, a, b));
        i_start    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        @(negedge clk);
        check_eq({tag, "_busy_acc"}, o_div_busy, 1);
        cyc = 0;
        busy_err = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_done) break;
            if (!o_div_busy) busy_err++;
        end
        i_start = 1'b0;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_lat"}, cyc, e.lat);
            check_eq({tag, "_busy_run"}, busy_err, 0);
            check_eq({tag, "_busy_done"}, o_div_busy, 0);
            check_eq({tag, "_q"}, o_quotient, e.q);
            check_eq({tag, "_r"}, o_remainder, e.r);
            check_eq({tag, "_dbz"}, o_div_by_zero, e.dbz);
            last_q = e.q;
            last_r = e.r;
            last_dbz = 32'(e.dbz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_seen;
        resetn     = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        i_flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_q", o_quotient, 0);
        check_eq("rst_r", o_remainder, 0);
        check_eq("rst_dbz", o_div_by_zero, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_busy", o_div_busy, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);
        do_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        do_div("div_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div("div_m2_m7", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF9);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (k % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            do_div("rand", k[0], ra, rb);
        end

        // flush in the middle of an iteration
        i_start    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        @(negedge clk);
        check_eq("fl_busy_acc", o_div_busy, 1);
        done_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) i_flush = 1'b1;
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check_eq("fl_busy", o_div_busy, 0);
        check_eq("fl_done_cnt", done_seen, 0);
        check_eq("fl_q_hold", o_quotient, last_q);
        check_eq("fl_r_hold", o_remainder, last_r);
        check_eq("fl_dbz_hold", o_div_by_zero, last_dbz);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        do_div("after_flush_20_6", 1'b0, 32'd20, 32'd6);

        // asynchronous reset in the middle of a divide
        i_start    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        repeat (15) @(posedge clk);
        #1;
        resetn  = 1'b0;
        i_start = 1'b0;
        #1;
        check_eq("mrst_q", o_quotient, 0);
        check_eq("mrst_r", o_remainder, 0);
        check_eq("mrst_dbz", o_div_by_zero, 0);
        check_eq("mrst_done", o_done, 0);
        check_eq("mrst_busy", o_div_busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_div("post_rst_100_7", 1'b0, 32'd100, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative 32-bit divide unit with its own sequencing FSM. It owns the shared divider resource for MIPS DIV/DIVU in the EXE stage. It drives `o_div_busy`, which freezes all four pipeline-register enables in the pipeline controller while a divide is in flight. It produces quotient/remainder for HI/LO writeback, and an exception flush cancels it.

## Interface
- `clk`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `i_start`  in  1  EXE holds a divide; level, held while stalled
- `i_signed`  in  1  1 = DIV (two's complement), 0 = DIVU
- `i_dividend`  in  32  rs operand, sampled at accept
- `i_divisor`  in  32  rt operand, sampled at accept
- `i_flush`  in  1  exception flush from MEM; cancels operation
- `o_div_busy`  out  1  stall request to pipeline controller
- `o_done`  out  1  one-cycle pulse: results valid, pipeline may advance
- `o_quotient`  out  32  LO value, held until next accept
- `o_remainder`  out  32  HI value, held until next accept
- `o_div_by_zero`  out  1  last accepted operation had divisor 0

## Operation
- States: IDLE, ITER, FIX, DONE.
- Accept happens in IDLE when `i_start & ~i_flush`. On accept:
  - Latch |dividend|, |divisor|, quotient sign (signed: sign(a) xor sign(b)) and remainder sign (sign(a)).
  - Clear the 33-bit partial remainder and the 6-bit iteration counter.
- Abs values are computed in 33 bits, so 0x80000000 is handled without overflow.
- Transitions from IDLE on accept:
  - Divisor 0 goes to FIX. It loads q=0xFFFFFFFF and r=i_dividend, and sets the dbz flag.
  - Otherwise it goes to ITER, or to the early-out path (see Configuration).
- ITER performs one restoring step per cycle, 32 steps in total:
  - Shift {rem, q} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep the difference and set the q LSB.
  - After step 32, go to FIX.
- FIX applies sign correction only if `i_signed`:
  - q negated if quotient sign is set.
  - r negated if remainder sign is set.
  - -2^31 / -1 yields q=0x80000000, r=0 with no trap.
  - Divide-by-zero results are not sign-corrected.
  - Results register into `o_quotient`/`o_remainder`/`o_div_by_zero`, then go to DONE.
- DONE: `o_done`=1, then return to IDLE. `i_start` is ignored in DONE; the instruction leaves EXE that cycle.
- `o_div_busy` = ~i_flush & ((IDLE & i_start) | ITER | FIX). It is combinational, so the stall takes effect in the accept cycle. It is 0 in DONE.
- `i_flush` sampled high in ITER/FIX/DONE: go to IDLE next edge.
  - Outputs are not updated and `o_done` is suppressed.
  - In DONE, the flush only suppresses `o_done`.
- Reset, including mid-operation: state IDLE, counter 0, `o_quotient`=0, `o_remainder`=0, `o_div_by_zero`=0, `o_done`=0. `o_div_busy`=0 while `i_start`=0.

## Timing
- Accept at cycle 0 (busy high).
- Normal path: ITER cycles 1–32, FIX cycle 33, DONE cycle 34 (`o_done`=1, busy=0).
- Divide-by-zero path: FIX cycle 1, DONE cycle 2.
- Back-to-back divides: the next accept can happen at cycle 35 (IDLE), with no bubble beyond DONE.
- Flush at cycle n (n≥1): IDLE at n+1. If `i_start` is high with no flush, a new accept happens at n+1.
- Results are stable from the DONE cycle until the edge after the next accept.

## Configuration
- `DIV_EARLY_OUT_EN` defined: at accept, if |dividend| < |divisor| and divisor ≠ 0, skip ITER.
  - Go directly to FIX with q=0, r=|dividend|, then apply sign correction.
  - Completes like the divide-by-zero path: DONE at cycle 2.
- Not defined: every nonzero divisor takes the full 32 ITER cycles. Results are identical; only latency differs.

## Test plan
- DIVU 100/7: accept at cycle 0 -> busy cycles 0–33, `o_done` at cycle 34, q=14, r=2, dbz=0.
- DIV -7/2 (0xFFFFFFF9/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- DIVU 5/0 -> `o_done` at cycle 2, q=0xFFFFFFFF, r=5, dbz=1. A following DIVU 9/3 clears dbz: q=3, r=0.
- DIVU 3/10 -> q=0, r=3. `o_done` at cycle 2 with `DIV_EARLY_OUT_EN`, at cycle 34 without.
- Start 100/7, `i_flush` at cycle 10 -> busy=0 in cycle 10 and after, no `o_done`, outputs keep prior values. New 20/6 at cycle 11 -> q=3, r=2 at cycle 45.
- Reset asserted at cycle 15 of a divide -> all outputs 0 immediately. After release, 100/7 completes normally in 34 cycles.
